// File: rtl/led_status_ctrl.sv
//------------------------------------------------------------------------------
// led_status_ctrl
//
// Purpose:
//   Shares one RGB LED between up to three status requesters. Channel 0 has
//   the highest priority. All LED drive is globally dimmed by a free-running
//   PWM counter, and each requester can ask for its colour to blink. After
//   every reset the controller first runs a red -> green -> blue lamp test.
//   It then serves requests until the next reset.
//
// Parameters:
//   PWM_BITS   - width of the free-running PWM counter
//   BRIGHT     - PWM duty threshold; the LED is lit while counter < BRIGHT
//   BLINK_HALF - clock cycles per blink half-period (>= 1)
//   LAMP_STEP  - clock cycles each lamp-test colour is shown (>= 1)
//
// Ports:
//   i_clk       - system clock
//   i_rst       - asynchronous active-high reset
//   i_req       - per-channel request, bit 0 = highest priority
//   i_color     - per-channel colour, channel n at [3n+2:3n] as {r,g,b}
//   i_blink     - per-channel blink enable
//   o_grant     - registered one-hot grant, 0 when nothing is served
//   o_led_r/g/b - registered PWM drive for the LED driver
//   o_lamp_test - high while the lamp-test sequence runs
//------------------------------------------------------------------------------
module led_status_ctrl #(
    parameter int unsigned         PWM_BITS   = 8,
    parameter logic [PWM_BITS-1:0] BRIGHT     = 8'h40,
    parameter int unsigned         BLINK_HALF = 24_000_000,
    parameter int unsigned         LAMP_STEP  = 24_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    input  logic [8:0] i_color,
    input  logic [2:0] i_blink,
    output logic [2:0] o_grant,
    output logic       o_led_r,
    output logic       o_led_g,
    output logic       o_led_b,
    output logic       o_lamp_test
);

    // Counter widths; a period of 1 still needs a 1-bit counter.
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned LAMP_W  = (LAMP_STEP  > 1) ? $clog2(LAMP_STEP)  : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [LAMP_W-1:0]  LAMP_LAST  = LAMP_W'(LAMP_STEP - 1);

    localparam logic [1:0] ST_LAMP_R = 2'd0;
    localparam logic [1:0] ST_LAMP_G = 2'd1;
    localparam logic [1:0] ST_LAMP_B = 2'd2;
    localparam logic [1:0] ST_SERVE  = 2'd3;

    // The borrow out of cnt - BRIGHT is set exactly when cnt < BRIGHT. This
    // avoids a relational compare that folds to a constant when BRIGHT = 0.
    function automatic logic f_pwm_on(input logic [PWM_BITS-1:0] cnt);
        logic [PWM_BITS:0] diff;
        diff = {1'b0, cnt} - {1'b0, BRIGHT};
        return diff[PWM_BITS];
    endfunction

    //--------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_phase;
    logic [LAMP_W-1:0]   r_lamp_cnt;
    logic [1:0]          r_state;
    logic [2:0]          r_grant;
    logic                r_lamp_test;
    logic [2:0]          r_led_p1;

    //--------------------------------------------------------------------
    // Combinational decode of the current state
    //--------------------------------------------------------------------
    logic       w_serve;
    logic       w_lamp_done;
    logic [2:0] w_grant_nxt;
    logic [2:0] w_color;
    logic       w_active;
    logic       w_blink_act;
    logic       w_grant_chg;
    logic       w_blink_wrap;
    logic [2:0] w_led_nxt;

    assign w_serve     = (r_state == ST_SERVE);
    assign w_lamp_done = (r_lamp_cnt == LAMP_LAST);

    // Fixed priority: lowest asserted index wins. Nothing is granted during
    // the lamp test, so requests present when SERVE is entered are picked
    // up on the following edge.
    always_comb begin
        w_grant_nxt = 3'b000;
        if (w_serve) begin
            if (i_req[0]) begin
                w_grant_nxt = 3'b001;
            end else if (i_req[1]) begin
                w_grant_nxt = 3'b010;
            end else if (i_req[2]) begin
                w_grant_nxt = 3'b100;
            end
        end
    end

    // Lamp states force their test colour; SERVE shows the live colour of
    // the currently granted channel, so a colour change appears one cycle
    // later without touching the blink timing.
    always_comb begin
        w_color = 3'b000;
        case (r_state)
            ST_LAMP_R: w_color = 3'b100;
            ST_LAMP_G: w_color = 3'b010;
            ST_LAMP_B: w_color = 3'b001;
            default: begin
                case (r_grant)
                    3'b001:  w_color = i_color[2:0];
                    3'b010:  w_color = i_color[5:3];
                    3'b100:  w_color = i_color[8:6];
                    default: w_color = 3'b000;
                endcase
            end
        endcase
    end

    assign w_active     = !w_serve || (r_grant != 3'b000);
    assign w_blink_act  = w_serve && ((i_blink & r_grant) != 3'b000);
    assign w_grant_chg  = (w_grant_nxt != r_grant);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_led_nxt    = w_color & {3{f_pwm_on(r_pwm_cnt) & r_phase & w_active}};

    //--------------------------------------------------------------------
    // Stage p0: counters, state machine and grant
    //--------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_LAMP_R;
            r_lamp_cnt <= '0;
        end else if (!w_serve) begin
            if (w_lamp_done) begin
                r_lamp_cnt <= '0;
                case (r_state)
                    ST_LAMP_R: r_state <= ST_LAMP_G;
                    ST_LAMP_G: r_state <= ST_LAMP_B;
                    default:   r_state <= ST_SERVE;
                endcase
            end else begin
                r_lamp_cnt <= r_lamp_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant <= 3'b000;
        end else begin
            r_grant <= w_grant_nxt;
        end
    end

    // A grant change restarts blinking in the on phase, even when it lands
    // on the same edge as a half-period wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_grant_chg || !w_blink_act) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_phase     <= !r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------
    // Stage p1: registered LED drive and lamp-test flag
    //--------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_led_p1    <= 3'b000;
            r_lamp_test <= 1'b0;
        end else begin
            r_led_p1    <= w_led_nxt;
            r_lamp_test <= !w_serve;
        end
    end

    assign o_grant     = r_grant;
    assign o_led_r     = r_led_p1[2];
    assign o_led_g     = r_led_p1[1];
    assign o_led_b     = r_led_p1[0];
    assign o_lamp_test = r_lamp_test;

endmodule
